// File: rtl/aho_pkg.sv
// Shared constants for the Aho-Corasick table writer and readers: record headers,
// default table geometry and the writer FSM encoding (checksum state only with TABLE_WRITER_CHECKSUM_EN).
package aho_pkg;

  localparam logic [7:0] REC_GOTO = 8'h01;
  localparam logic [7:0] REC_FAIL = 8'h02;
  localparam logic [7:0] REC_END  = 8'hFF;

  localparam int DEF_GOTO_DEPTH = 32;
  localparam int DEF_FAIL_DEPTH = 32;
  localparam int DEF_STATE_W    = 8;
  localparam int DEF_CHAR_W     = 8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_HDR    = 4'd1,
    ST_G_CUR  = 4'd2,
    ST_G_CHR  = 4'd3,
    ST_G_NXT  = 4'd4,
    ST_F_ST   = 4'd5,
    ST_F_FAIL = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERROR  = 4'd8
`ifdef TABLE_WRITER_CHECKSUM_EN
    , ST_CHK  = 4'd9
`endif
  } state_e;

  // States in which the writer consumes record bytes.
  function automatic logic accepts_bytes(input state_e s);
    logic r;
    r = (s == ST_HDR) || (s == ST_G_CUR) || (s == ST_G_CHR) || (s == ST_G_NXT) ||
        (s == ST_F_ST) || (s == ST_F_FAIL);
`ifdef TABLE_WRITER_CHECKSUM_EN
    r = r || (s == ST_CHK);
`endif
    return r;
  endfunction

endpackage

// File: rtl/aho_table_writer.sv
// Byte-serial loader for the goto/failure tables. Optional END checksum byte is built
// only when TABLE_WRITER_CHECKSUM_EN is defined.
module aho_table_writer
  import aho_pkg::*;
#(
  parameter int GOTO_DEPTH = DEF_GOTO_DEPTH,
  parameter int FAIL_DEPTH = DEF_FAIL_DEPTH,
  parameter int STATE_W    = DEF_STATE_W,
  parameter int CHAR_W     = DEF_CHAR_W
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          START,
  input  logic                          IN_VALID,
  input  logic [7:0]                    IN_DATA,
  output logic                          IN_READY,
  output logic                          GOTO_WE,
  output logic [$clog2(GOTO_DEPTH)-1:0] GOTO_ADDR,
  output logic [STATE_W-1:0]            GOTO_CUR,
  output logic [CHAR_W-1:0]             GOTO_CHARA,
  output logic [STATE_W-1:0]            GOTO_NEXT,
  output logic                          FAIL_WE,
  output logic [$clog2(FAIL_DEPTH)-1:0] FAIL_ADDR,
  output logic [STATE_W-1:0]            FAIL_DATA,
  output logic [$clog2(GOTO_DEPTH):0]   GOTO_COUNT,
  output logic                          TABLE_READY,
  output logic                          ERR,
  output state_e                        DBG_STATE
);

  localparam int GA_W  = $clog2(GOTO_DEPTH);
  localparam int FA_W  = $clog2(FAIL_DEPTH);
  localparam int CNT_W = GA_W + 1;

  // Handshake: a byte transfers on a rising edge where IN_VALID and IN_READY are both high;
  // IN_VALID may be held while IN_READY is low, and START in the same cycle drops the byte.
  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                goto_we_q, goto_we_d;
  logic [GA_W-1:0]     goto_addr_q, goto_addr_d;
  logic [STATE_W-1:0]  goto_cur_q, goto_cur_d;
  logic [CHAR_W-1:0]   goto_chara_q, goto_chara_d;
  logic [STATE_W-1:0]  goto_next_q, goto_next_d;
  logic                fail_we_q, fail_we_d;
  logic [FA_W-1:0]     fail_addr_q, fail_addr_d;
  logic [STATE_W-1:0]  fail_data_q, fail_data_d;
  logic [STATE_W-1:0]  fail_st_q, fail_st_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
`ifdef TABLE_WRITER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif
  logic                hs;

  assign hs = IN_VALID && in_ready_q;

  always_comb begin
    state_d      = state_q;
    goto_we_d    = 1'b0;
    goto_addr_d  = goto_addr_q;
    goto_cur_d   = goto_cur_q;
    goto_chara_d = goto_chara_q;
    goto_next_d  = goto_next_q;
    fail_we_d    = 1'b0;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    fail_st_d    = fail_st_q;
    count_d      = count_q;
    ready_d      = ready_q;
    err_d        = err_q;
`ifdef TABLE_WRITER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    if (START) begin
      state_d = ST_HDR;
      count_d = '0;
      ready_d = 1'b0;
      err_d   = 1'b0;
`ifdef TABLE_WRITER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else if (hs) begin
`ifdef TABLE_WRITER_CHECKSUM_EN
      csum_d = csum_q ^ IN_DATA;
`endif
      case (state_q)
        ST_HDR: begin
          if (IN_DATA == REC_GOTO) begin
            if (count_q == CNT_W'(GOTO_DEPTH)) begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end else begin
              state_d = ST_G_CUR;
            end
          end else if (IN_DATA == REC_FAIL) begin
            state_d = ST_F_ST;
          end else if (IN_DATA == REC_END) begin
`ifdef TABLE_WRITER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
            ready_d = 1'b1;
`endif
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
        ST_G_CUR: begin
          goto_cur_d = STATE_W'(IN_DATA);
          state_d    = ST_G_CHR;
        end
        ST_G_CHR: begin
          goto_chara_d = CHAR_W'(IN_DATA);
          state_d      = ST_G_NXT;
        end
        ST_G_NXT: begin
          goto_next_d = STATE_W'(IN_DATA);
          goto_addr_d = count_q[GA_W-1:0];
          goto_we_d   = 1'b1;
          count_d     = count_q + CNT_W'(1);
          state_d     = ST_HDR;
        end
        ST_F_ST: begin
          fail_st_d = STATE_W'(IN_DATA);
          state_d   = ST_F_FAIL;
        end
        ST_F_FAIL: begin
          // State numbers are 1-based; state 0 has no failure entry.
          if ((fail_st_q == '0) || (fail_st_q > STATE_W'(FAIL_DEPTH))) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            fail_addr_d = FA_W'(fail_st_q - STATE_W'(1));
            fail_data_d = STATE_W'(IN_DATA);
            fail_we_d   = 1'b1;
            state_d     = ST_HDR;
          end
        end
`ifdef TABLE_WRITER_CHECKSUM_EN
        ST_CHK: begin
          if (IN_DATA == csum_q) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
`endif
        default: state_d = state_q;
      endcase
    end
    in_ready_d = accepts_bytes(state_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      goto_we_q    <= 1'b0;
      goto_addr_q  <= '0;
      goto_cur_q   <= '0;
      goto_chara_q <= '0;
      goto_next_q  <= '0;
      fail_we_q    <= 1'b0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_st_q    <= '0;
      count_q      <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
`ifdef TABLE_WRITER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      goto_we_q    <= goto_we_d;
      goto_addr_q  <= goto_addr_d;
      goto_cur_q   <= goto_cur_d;
      goto_chara_q <= goto_chara_d;
      goto_next_q  <= goto_next_d;
      fail_we_q    <= fail_we_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
      fail_st_q    <= fail_st_d;
      count_q      <= count_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
`ifdef TABLE_WRITER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign IN_READY    = in_ready_q;
  assign GOTO_WE     = goto_we_q;
  assign GOTO_ADDR   = goto_addr_q;
  assign GOTO_CUR    = goto_cur_q;
  assign GOTO_CHARA  = goto_chara_q;
  assign GOTO_NEXT   = goto_next_q;
  assign FAIL_WE     = fail_we_q;
  assign FAIL_ADDR   = fail_addr_q;
  assign FAIL_DATA   = fail_data_q;
  assign GOTO_COUNT  = count_q;
  assign TABLE_READY = ready_q;
  assign ERR         = err_q;
  assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_aho_table_writer.sv
// Self-checking bench for aho_table_writer; write strobes are scored against expected queues.
module tb_aho_table_writer;
  import aho_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [7:0]  IN_DATA = 8'h00;
  logic        IN_READY;
  logic        GOTO_WE;
  logic [4:0]  GOTO_ADDR;
  logic [7:0]  GOTO_CUR;
  logic [7:0]  GOTO_CHARA;
  logic [7:0]  GOTO_NEXT;
  logic        FAIL_WE;
  logic [4:0]  FAIL_ADDR;
  logic [7:0]  FAIL_DATA;
  logic [5:0]  GOTO_COUNT;
  logic        TABLE_READY;
  logic        ERR;
  state_e      DBG_STATE;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  bench_csum = 8'h00;
  logic [28:0] exp_goto_q[$];
  logic [12:0] exp_fail_q[$];

  aho_table_writer dut (
    .CLK(CLK), .RST(RST), .START(START), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_READY(IN_READY), .GOTO_WE(GOTO_WE), .GOTO_ADDR(GOTO_ADDR), .GOTO_CUR(GOTO_CUR),
    .GOTO_CHARA(GOTO_CHARA), .GOTO_NEXT(GOTO_NEXT), .FAIL_WE(FAIL_WE), .FAIL_ADDR(FAIL_ADDR),
    .FAIL_DATA(FAIL_DATA), .GOTO_COUNT(GOTO_COUNT), .TABLE_READY(TABLE_READY), .ERR(ERR),
    .DBG_STATE(DBG_STATE)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Scoreboard: every strobe cycle pops one expected write; a strobe with nothing expected fails.
  always @(negedge CLK) begin
    if (!RST && GOTO_WE === 1'b1) begin
      logic [28:0] exp_g;
      n_cmp++;
      if (exp_goto_q.size() == 0) begin
        n_err++;
        $display("FAIL goto_unexpected got addr=%0d cur=%h ch=%h nxt=%h expected no strobe",
                 GOTO_ADDR, GOTO_CUR, GOTO_CHARA, GOTO_NEXT);
      end else begin
        exp_g = exp_goto_q.pop_front();
        if ({GOTO_ADDR, GOTO_CUR, GOTO_CHARA, GOTO_NEXT} !== exp_g) begin
          n_err++;
          $display("FAIL goto_write got %h expected %h",
                   {GOTO_ADDR, GOTO_CUR, GOTO_CHARA, GOTO_NEXT}, exp_g);
        end
      end
    end
    if (!RST && FAIL_WE === 1'b1) begin
      logic [12:0] exp_f;
      n_cmp++;
      if (exp_fail_q.size() == 0) begin
        n_err++;
        $display("FAIL fail_unexpected got addr=%0d data=%h expected no strobe", FAIL_ADDR, FAIL_DATA);
      end else begin
        exp_f = exp_fail_q.pop_front();
        if ({FAIL_ADDR, FAIL_DATA} !== exp_f) begin
          n_err++;
          $display("FAIL fail_write got %h expected %h", {FAIL_ADDR, FAIL_DATA}, exp_f);
        end
      end
    end
  end

  // Driver tasks: all drives happen 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    bench_csum = 8'h00;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    IN_VALID = 1'b1;
    IN_DATA  = b;
    @(negedge CLK);
    while (IN_READY !== 1'b1 && n < 20) begin
      n++;
      @(negedge CLK);
    end
    if (IN_READY !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout got IN_READY=%b expected 1 for byte %h", IN_READY, b);
    end else begin
      bench_csum = bench_csum ^ b;
    end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic send_goto(input logic [4:0] addr, input logic [7:0] cur,
                           input logic [7:0] ch, input logic [7:0] nxt);
    exp_goto_q.push_back({addr, cur, ch, nxt});
    send_byte(REC_GOTO); send_byte(cur); send_byte(ch); send_byte(nxt);
  endtask

  task automatic send_end();
    logic [7:0] c;
    send_byte(REC_END);
`ifdef TABLE_WRITER_CHECKSUM_EN
    c = bench_csum;
    send_byte(c);
`else
    c = 8'h00;
`endif
  endtask

  task automatic check_flags(input string name, input logic rdy, input logic err,
                             input logic inr, input logic [5:0] cnt);
    n_cmp++;
    if ({TABLE_READY, ERR, IN_READY, GOTO_COUNT} !== {rdy, err, inr, cnt}) begin
      n_err++;
      $display("FAIL %s got ready=%b err=%b in_ready=%b count=%0d expected ready=%b err=%b in_ready=%b count=%0d",
               name, TABLE_READY, ERR, IN_READY, GOTO_COUNT, rdy, err, inr, cnt);
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_goto_q.size() != 0 || exp_fail_q.size() != 0) begin
      n_err++;
      $display("FAIL %s got pending goto=%0d fail=%0d expected 0/0",
               name, exp_goto_q.size(), exp_fail_q.size());
      exp_goto_q.delete();
      exp_fail_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({IN_READY, GOTO_WE, GOTO_ADDR, GOTO_CUR, GOTO_CHARA, GOTO_NEXT, FAIL_WE, FAIL_ADDR,
         FAIL_DATA, GOTO_COUNT, TABLE_READY, ERR} !== '0) begin
      n_err++;
      $display("FAIL %s got nonzero outputs rdy=%b gwe=%b cnt=%0d tr=%b err=%b fwe=%b expected all 0",
               name, IN_READY, GOTO_WE, GOTO_COUNT, TABLE_READY, ERR, FAIL_WE);
    end
    n_cmp++;
    if (DBG_STATE !== ST_IDLE) begin
      n_err++;
      $display("FAIL %s_state got %0d expected %0d", name, DBG_STATE, ST_IDLE);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    RST = 1'b1;
    idle(3);
    check_all_zero("reset");
    RST = 1'b0;
    idle(2);
    check_flags("idle_no_ready", 1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic test_goto_single();
    pulse_start();
    check_flags("start_hdr", 1'b0, 1'b0, 1'b1, 6'd0);
    send_goto(5'd0, 8'h00, 8'h61, 8'h01);
    send_end();
    idle(3);
    check_flags("goto_single", 1'b1, 1'b0, 1'b0, 6'd1);
    check_drained("goto_single_drain");
  endtask

  task automatic test_fail_write();
    pulse_start();
    check_flags("start_clears_ready", 1'b0, 1'b0, 1'b1, 6'd0);
    exp_fail_q.push_back({5'd2, 8'h01});
    send_byte(REC_FAIL); send_byte(8'h03); send_byte(8'h01);
    exp_fail_q.push_back({5'd31, 8'h07});
    send_byte(REC_FAIL); send_byte(8'h20); send_byte(8'h07);
    exp_fail_q.push_back({5'd0, 8'h0A});
    send_byte(REC_FAIL); send_byte(8'h01); send_byte(8'h0A);
    send_goto(5'd0, 8'h02, 8'h62, 8'h03);
    send_end();
    idle(3);
    check_flags("fail_write", 1'b1, 1'b0, 1'b0, 6'd1);
    check_drained("fail_write_drain");
  endtask

  task automatic test_fail_bad();
    pulse_start();
    send_byte(REC_FAIL); send_byte(8'h00); send_byte(8'h05);
    idle(3);
    check_flags("fail_state0", 1'b0, 1'b1, 1'b0, 6'd0);
    pulse_start();
    check_flags("start_clears_err", 1'b0, 1'b0, 1'b1, 6'd0);
    send_byte(REC_FAIL); send_byte(8'h21); send_byte(8'h05);
    idle(3);
    check_flags("fail_state33", 1'b0, 1'b1, 1'b0, 6'd0);
    pulse_start();
    send_byte(8'h37);
    idle(3);
    check_flags("bad_header", 1'b0, 1'b1, 1'b0, 6'd0);
    check_drained("fail_bad_drain");
  endtask

  task automatic test_goto_full();
    pulse_start();
    for (int i = 0; i < 32; i++)
      send_goto(5'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)));
    idle(2);
    check_flags("goto_32", 1'b0, 1'b0, 1'b1, 6'd32);
    send_byte(REC_GOTO);
    idle(3);
    check_flags("goto_full", 1'b0, 1'b1, 1'b0, 6'd32);
    check_drained("goto_full_drain");
  endtask

  task automatic test_reset_mid_record();
    pulse_start();
    send_byte(REC_GOTO); send_byte(8'h00);
    RST = 1'b1;
    idle(2);
    check_all_zero("reset_mid");
    RST = 1'b0;
    idle(2);
    pulse_start();
    send_end();
    idle(3);
    check_flags("reset_mid_end", 1'b1, 1'b0, 1'b0, 6'd0);
    check_drained("reset_mid_drain");
  endtask

  task automatic test_start_wins();
    pulse_start();
    // Offer an illegal header together with START; it must be dropped.
    IN_VALID = 1'b1;
    IN_DATA  = 8'h55;
    START    = 1'b1;
    bench_csum = 8'h00;
    @(posedge CLK);
    #1;
    START = 1'b0;
    IN_VALID = 1'b0;
    idle(1);
    check_flags("start_wins", 1'b0, 1'b0, 1'b1, 6'd0);
    send_goto(5'd0, 8'h04, 8'h63, 8'h05);
    send_goto(5'd1, 8'h05, 8'h64, 8'h06);
    send_end();
    idle(3);
    check_flags("back_to_back", 1'b1, 1'b0, 1'b0, 6'd2);
    check_drained("start_wins_drain");
  endtask

`ifdef TABLE_WRITER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_goto(5'd0, 8'h00, 8'h61, 8'h01);
    send_byte(REC_END);
    send_byte(8'h9E);
    idle(3);
    check_flags("csum_good", 1'b1, 1'b0, 1'b0, 6'd1);
    pulse_start();
    send_goto(5'd0, 8'h00, 8'h61, 8'h01);
    send_byte(REC_END);
    send_byte(8'h00);
    idle(3);
    check_flags("csum_bad", 1'b0, 1'b1, 1'b0, 6'd1);
    check_drained("csum_drain");
  endtask
`endif

  initial begin
    test_reset();
    test_goto_single();
    test_fail_write();
    test_fail_bad();
    test_goto_full();
    test_reset_mid_record();
    test_start_wins();
`ifdef TABLE_WRITER_CHECKSUM_EN
    test_checksum();
`endif
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
